signed_accum_sat: RTL and testbench
===================================

# signed_accum_sat

Parametrised streaming signed accumulator. Sums a packet of WIDTH-bit two's-complement samples into an ACC_WIDTH-bit accumulator, with selectable wrap or saturating arithmetic and a sticky signed-overflow flag per packet. Uses valid/ready handshakes on both sides and returns one registered result per packet. Intended as the datapath building block upstream of scaling and averaging stages.

## Interface
- WIDTH, 8: input sample width, signed two's complement.
- ACC_WIDTH, 8: accumulator and result width; must be ≥ WIDTH.
- SATURATE, 1: 1 clamps on overflow; 0 wraps modulo 2^ACC_WIDTH.
- COUNT_WIDTH, 8: sample-counter width.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  signed sample.
- in_last  input  1  marks the final sample of a packet; qualified by in_valid & in_ready.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_WIDTH  signed packet sum.
- out_ovf  output  1  one or more signed overflows occurred in this packet.
- out_count  output  COUNT_WIDTH  number of samples in the packet; saturates at all-ones.

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- in_ready = (state == ACCUM). out_valid = (state == HOLD).
- Accept = in_valid & in_ready. On each accept:
  - x = sign-extend(in_data) to ACC_WIDTH.
  - r = acc + x, truncated to ACC_WIDTH.
  - Overflow: acc[MSB] == x[MSB] and r[MSB] != acc[MSB].
  - With SATURATE=1 and overflow: acc ← 0111..1 when both operands are non-negative, or 1000..0 when both are negative. Otherwise acc ← r.
  - ovf_sticky ← ovf_sticky | overflow.
  - count ← count + 1, holding at all-ones.
- Later samples add to the clamped value. Example with 8-bit saturation: 127 + (−10) = 117.
- Accepting with in_last=1:
  - Load out_sum, out_ovf and out_count from the post-update values, which include the last sample.
  - Enter HOLD.
  - Clear acc, ovf_sticky and count to 0 for the next packet.
- A single-sample packet (in_last on the first sample) yields out_sum = sign-extended sample and count = 1.
- HOLD:
  - Outputs are stable.
  - in_valid is ignored and no sample is consumed.
  - out_ready=1 returns the block to ACCUM on the next edge.
- out_sum, out_ovf and out_count keep their last values after the handshake, but are meaningful only while out_valid=1.

## Timing
- Reset asserted, asynchronous effect:
  - state=ACCUM, acc=0, ovf_sticky=0, count=0.
  - out_sum=0, out_ovf=0, out_count=0, out_valid=0, in_ready=1.
- Reset mid-packet discards the partial sum. Reset during HOLD drops the pending result.
- Throughput: one sample per cycle in ACCUM.
- Latency: out_valid rises on the edge that accepts the last sample, i.e. one cycle after it is presented.
- Minimum dead time between packets is one cycle, because in_ready=0 for at least one cycle in HOLD.
- Asserting out_ready while out_valid=0 has no effect.
- A held result is never modified by input activity.

## Test plan
Default configuration: WIDTH=8, ACC_WIDTH=8.

- **Saturate, positive overflow.** SATURATE=1, samples 100 then 50 (last) → out_sum=127 (0x7F), out_ovf=1, out_count=2, out_valid one cycle after the last sample is accepted.
- **Wrap mode.** SATURATE=0.
  - 100, 50 (last) → out_sum=0x96 (−106), out_ovf=1.
  - −100, −50 (last) → 0x6A (106), out_ovf=1.
  - With SATURATE=1, the same negative pair → 0x80 (−128), out_ovf=1.
- **Continue from clamp.** SATURATE=1, samples 100, 100, −10 (last) → out_sum=117, out_ovf=1 (sticky), out_count=3.
- **Wide accumulator.** ACC_WIDTH=10, samples 100, 50 (last) → out_sum=150, out_ovf=0.
- **Backpressure.**
  - Hold out_ready=0 for 3 cycles after a result while driving in_valid=1 with in_data=9.
  - Required: out_valid stays 1, out_sum is unchanged, in_ready=0, no sample is consumed.
  - Then release out_ready and send 5, −3 (last) → out_sum=2, out_ovf=0 (sticky cleared), out_count=2.
- **Reset cases.**
  - Reset asserted mid-packet after samples 20, 30, then 7 (last) → out_sum=7, out_count=1.
  - Reset during HOLD → out_valid drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/signed_accum_sat.sv
// Streaming signed packet accumulator with selectable wrap or saturating
// arithmetic, a sticky per-packet overflow flag and a saturating sample count.
// One registered result per packet, handed off with valid/ready.
module signed_accum_sat #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 8,
    parameter bit SATURATE    = 1'b1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic                   out_ovf,
    output logic [COUNT_WIDTH-1:0] out_count
);

    if (ACC_WIDTH < WIDTH) begin : g_width_check
        $error("signed_accum_sat: ACC_WIDTH must be >= WIDTH");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state, state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   ovf_sticky;
    logic [COUNT_WIDTH-1:0] count;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   x;
    logic [ACC_WIDTH-1:0]   r;
    logic                   ovf;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   ovf_next;
    logic [COUNT_WIDTH-1:0] count_next;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    // Add the sign-extended sample; detect signed overflow and clamp if enabled.
    always_comb begin
        x   = ACC_WIDTH'($signed(in_data));
        r   = acc + x;
        ovf = (acc[ACC_WIDTH-1] == x[ACC_WIDTH-1]) && (r[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        acc_next = r;
        if (SATURATE && ovf) begin
            // Operands share a sign when overflow occurs; that sign picks the rail.
            acc_next = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        ovf_next   = ovf_sticky | ovf;
        count_next = (&count) ? count : count + COUNT_WIDTH'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    // Next state: last accepted sample enters HOLD, consumer handshake leaves it.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && in_last) state_next = HOLD;
            HOLD:  if (out_ready)         state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Running packet state and result registers; the result is loaded from the
    // post-update values so it includes the last sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
            count      <= '0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
            out_count  <= '0;
        end else if (accept) begin
            if (in_last) begin
                out_sum    <= acc_next;
                out_ovf    <= ovf_next;
                out_count  <= count_next;
                acc        <= '0;
                ovf_sticky <= 1'b0;
                count      <= '0;
            end else begin
                acc        <= acc_next;
                ovf_sticky <= ovf_next;
                count      <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_signed_accum_sat.sv
// Directed bench for signed_accum_sat: three instances (8-bit saturating,
// 8-bit wrapping, 10-bit saturating) share one input stream.
module tb_signed_accum_sat;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy_s, rdy_w, rdy_x;
    logic       vld_s, vld_w, vld_x;
    logic [7:0] sum_s, sum_w;
    logic [9:0] sum_x;
    logic       ovf_s, ovf_w, ovf_x;
    logic [7:0] cnt_s, cnt_w, cnt_x;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_accum_sat #(.WIDTH(8), .ACC_WIDTH(8), .SATURATE(1'b1), .COUNT_WIDTH(8)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_ovf(ovf_s), .out_count(cnt_s));

    signed_accum_sat #(.WIDTH(8), .ACC_WIDTH(8), .SATURATE(1'b0), .COUNT_WIDTH(8)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
        .out_sum(sum_w), .out_ovf(ovf_w), .out_count(cnt_w));

    signed_accum_sat #(.WIDTH(8), .ACC_WIDTH(10), .SATURATE(1'b1), .COUNT_WIDTH(8)) u_wide (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_x),
        .in_data(in_data), .in_last(in_last), .out_valid(vld_x), .out_ready(out_ready),
        .out_sum(sum_x), .out_ovf(ovf_x), .out_count(cnt_x));

    typedef struct {
        string      name;
        int         n;
        int         s0, s1, s2;
        logic [7:0] sat_sum;
        logic       sat_ovf;
        logic [7:0] wrap_sum;
        logic       wrap_ovf;
        logic [9:0] wide_sum;
        logic       wide_ovf;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input int n, input int s0, input int s1, input int s2,
                           input logic [7:0] ss, input logic so, input logic [7:0] ws, input logic wo,
                           input logic [9:0] xs, input logic xo, input logic [7:0] c);
        vec_t v;
        v.name = name; v.n = n; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.sat_sum = ss; v.sat_ovf = so; v.wrap_sum = ws; v.wrap_ovf = wo;
        v.wide_sum = xs; v.wide_ovf = xo; v.cnt = c;
        vecs.push_back(v);
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic send(input int s, input logic last);
        int t;
        in_valid = 1'b1;
        in_data  = 8'(s);
        in_last  = last;
        t = 0;
        while (!rdy_s && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 10) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_drained"}, {29'd0, vld_s, vld_w, vld_x}, 32'd0);
        check({name, "_ready_back"}, {29'd0, rdy_s, rdy_w, rdy_x}, 32'h7);
    endtask

    task automatic check_result(input string name, input logic [7:0] ss, input logic so,
                                input logic [7:0] ws, input logic wo, input logic [9:0] xs,
                                input logic xo, input logic [7:0] c);
        check({name, "_valid"}, {29'd0, vld_s, vld_w, vld_x}, 32'h7);
        check({name, "_in_ready"}, {29'd0, rdy_s, rdy_w, rdy_x}, 32'h0);
        check({name, "_sat_sum"}, {24'd0, sum_s}, {24'd0, ss});
        check({name, "_sat_ovf"}, {31'd0, ovf_s}, {31'd0, so});
        check({name, "_wrap_sum"}, {24'd0, sum_w}, {24'd0, ws});
        check({name, "_wrap_ovf"}, {31'd0, ovf_w}, {31'd0, wo});
        check({name, "_wide_sum"}, {22'd0, sum_x}, {22'd0, xs});
        check({name, "_wide_ovf"}, {31'd0, ovf_x}, {31'd0, xo});
        check({name, "_count"}, {8'd0, cnt_s, cnt_w, cnt_x}, {8'd0, c, c, c});
    endtask

    initial begin
        logic [7:0] held;

        //       name        n  s0    s1    s2    sat   so    wrap  wo    wide    xo    cnt
        add_vec("pos_ovf",   2, 100,  50,   0,   8'h7F, 1'b1, 8'h96, 1'b1, 10'h096, 1'b0, 8'd2);
        add_vec("neg_ovf",   2, -100, -50,  0,   8'h80, 1'b1, 8'h6A, 1'b1, 10'h36A, 1'b0, 8'd2);
        add_vec("clamp_cont",3, 100,  100,  -10, 8'h75, 1'b1, 8'hBE, 1'b1, 10'h0BE, 1'b0, 8'd3);
        add_vec("single_pos",1, 7,    0,    0,   8'h07, 1'b0, 8'h07, 1'b0, 10'h007, 1'b0, 8'd1);
        add_vec("single_neg",1, -1,   0,    0,   8'hFF, 1'b0, 8'hFF, 1'b0, 10'h3FF, 1'b0, 8'd1);
        add_vec("edge_max",  2, 127,  1,    0,   8'h7F, 1'b1, 8'h80, 1'b1, 10'h080, 1'b0, 8'd2);
        add_vec("no_ovf",    2, 5,    -3,   0,   8'h02, 1'b0, 8'h02, 1'b0, 10'h002, 1'b0, 8'd2);

        // Reset state, checked while reset is still asserted.
        #12;
        check("rst_valid", {29'd0, vld_s, vld_w, vld_x}, 32'h0);
        check("rst_ready", {29'd0, rdy_s, rdy_w, rdy_x}, 32'h7);
        check("rst_sum", {sum_x, sum_w, sum_s}, 32'h0);
        check("rst_flags", {ovf_s, ovf_w, ovf_x, cnt_s, cnt_w, cnt_x}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven packets.
        foreach (vecs[i]) begin
            int smp[3];
            smp[0] = vecs[i].s0; smp[1] = vecs[i].s1; smp[2] = vecs[i].s2;
            for (int k = 0; k < vecs[i].n; k++) send(smp[k], k == vecs[i].n - 1);
            check_result(vecs[i].name, vecs[i].sat_sum, vecs[i].sat_ovf, vecs[i].wrap_sum,
                         vecs[i].wrap_ovf, vecs[i].wide_sum, vecs[i].wide_ovf, vecs[i].cnt);
            release_result(vecs[i].name);
        end

        // Backpressure: HOLD ignores input, then sticky flag is cleared for the next packet.
        send(100, 1'b0);
        send(50, 1'b1);
        held = sum_s;
        check("bp_held_init", {24'd0, held}, 32'h7F);
        in_valid = 1'b1;
        in_data  = 8'd9;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_valid", {29'd0, vld_s, vld_w, vld_x}, 32'h7);
            check("bp_ready", {29'd0, rdy_s, rdy_w, rdy_x}, 32'h0);
            check("bp_sum", {24'd0, sum_s}, {24'd0, held});
            check("bp_count", {24'd0, cnt_s}, 32'd2);
        end
        in_valid = 1'b0;
        release_result("bp");
        send(5, 1'b0);
        send(-3, 1'b1);
        check_result("bp_after", 8'h02, 1'b0, 8'h02, 1'b0, 10'h002, 1'b0, 8'd2);
        release_result("bp_after");

        // Count saturation: 300 samples of +1.
        for (int k = 0; k < 300; k++) send(1, k == 299);
        check_result("long", 8'h7F, 1'b1, 8'h2C, 1'b1, 10'h12C, 1'b0, 8'hFF);
        release_result("long");

        // Reset mid-packet discards the partial sum.
        send(20, 1'b0);
        send(30, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midrst_ready", {29'd0, rdy_s, rdy_w, rdy_x}, 32'h7);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send(7, 1'b1);
        check_result("midrst", 8'h07, 1'b0, 8'h07, 1'b0, 10'h007, 1'b0, 8'd1);

        // Reset during HOLD drops out_valid without a clock edge.
        #2 reset = 1'b1;
        #1;
        check("holdrst_valid", {29'd0, vld_s, vld_w, vld_x}, 32'h0);
        check("holdrst_sum", {sum_x, sum_w, sum_s}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
